// File: rtl/traffic_lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_pkg
// Description : Shared types and constants for the traffic light command
//               deserializer: command type enum, header magic nibble,
//               deserializer FSM state type and a payload-length helper.
//               Optional macro TL_CMD_RANGE_CHECK_EN is consumed by the top.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_lights_pkg;

    typedef enum logic [2:0] {
        CMD_ON       = 3'd0,
        CMD_OFF      = 3'd1,
        CMD_YBLINK   = 3'd2,
        CMD_GREEN_T  = 3'd3,
        CMD_RED_T    = 3'd4,
        CMD_YELLOW_T = 3'd5
    } cmd_type_e;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA_LO = 2'd1,
        DATA_HI = 2'd2,
        EMIT    = 2'd3
    } deser_state_e;

    // Timed commands (green/red/yellow) carry a 16-bit payload.
    function automatic logic type_has_data(input logic [2:0] t);
        return (t == CMD_GREEN_T) || (t == CMD_RED_T) || (t == CMD_YELLOW_T);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timeout_timer
// Description : 16-bit inter-byte gap counter. Counts while enabled, clears
//               on request, and flags expiry in the cycle where the count
//               has reached TIMEOUT_CLK-1 while still enabled.
// Ports       : clk, rst (async, active-high), clr_i, en_i, exp_o
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timeout_timer #(
    parameter int TIMEOUT_CLK = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic exp_o
);

    localparam logic [15:0] C_LAST = 16'(TIMEOUT_CLK - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 16'd0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign exp_o = en_i && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/traffic_lights_cmd_deser.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_cmd_deser
// Description : Byte-stream command deserializer. Validates a header byte
//               (magic 4'hA, bit3 clear, 3-bit type), collects an optional
//               16-bit LSB-first payload and emits one command strobe per
//               frame. Bad headers and stalled frames pulse frame_err_o.
// Ports       : clk_0m002, arst_i (async, active-high)
//               byte_i/byte_val_i/byte_rdy_o : byte input handshake
//               cmd_type_o/cmd_data_o/cmd_val_o : command to controller
//               frame_err_o : one-cycle drop indication
// Config      : TL_CMD_RANGE_CHECK_EN - reject types 6/7 and zero payloads
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_lights_cmd_deser
    import traffic_lights_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 2000,
    parameter int FRAME_TIMEOUT_MS = 500
) (
    input  logic        clk_0m002,
    input  logic        arst_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_val_i,
    output logic        byte_rdy_o,
    output logic [2:0]  cmd_type_o,
    output logic [15:0] cmd_data_o,
    output logic        cmd_val_o,
    output logic        frame_err_o
);

    localparam int TIMEOUT_CLK = CLK_FREQ_HZ * FRAME_TIMEOUT_MS / 1000;

    deser_state_e state_q, state_d;
    logic [2:0]   type_q, type_d;
    logic [7:0]   lo_q, lo_d;
    logic [2:0]   cmd_type_q, cmd_type_d;
    logic [15:0]  cmd_data_q, cmd_data_d;
    logic         rdy_q, rdy_d;
    logic         err_q, err_d;

    logic         byte_acc;
    logic         in_data;
    logic         tmo;
    logic         hdr_bad;
    logic         data_bad;

    assign byte_acc = byte_val_i & rdy_q;
    assign in_data  = (state_q == DATA_LO) || (state_q == DATA_HI);

    `ifdef TL_CMD_RANGE_CHECK_EN
    assign hdr_bad  = (byte_i[7:4] != HDR_MAGIC) || byte_i[3] || (byte_i[2:1] == 2'b11);
    assign data_bad = ({byte_i, lo_q} == 16'd0);
    `else
    assign hdr_bad  = (byte_i[7:4] != HDR_MAGIC) || byte_i[3];
    assign data_bad = 1'b0;
    `endif

    // The timer only runs on idle cycles inside a payload; it restarts on
    // any accepted byte, outside payload states and once it has fired.
    frame_timeout_timer #(
        .TIMEOUT_CLK (TIMEOUT_CLK)
    ) u_timer (
        .clk   (clk_0m002),
        .rst   (arst_i),
        .clr_i (byte_acc | ~in_data | tmo),
        .en_i  (in_data & ~byte_acc),
        .exp_o (tmo)
    );

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        lo_d       = lo_q;
        cmd_type_d = cmd_type_q;
        cmd_data_d = cmd_data_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (byte_acc) begin
                    if (hdr_bad) begin
                        err_d = 1'b1;
                    end else if (type_has_data(byte_i[2:0])) begin
                        type_d  = byte_i[2:0];
                        state_d = DATA_LO;
                    end else begin
                        cmd_type_d = byte_i[2:0];
                        cmd_data_d = 16'd0;
                        state_d    = EMIT;
                    end
                end
            end
            DATA_LO: begin
                if (byte_acc) begin
                    lo_d    = byte_i;
                    state_d = DATA_HI;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DATA_HI: begin
                if (byte_acc) begin
                    if (data_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cmd_type_d = type_q;
                        cmd_data_d = {byte_i, lo_q};
                        state_d    = EMIT;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered ready: low during reset and for the EMIT cycle only.
        rdy_d = (state_d != EMIT);
    end

    always_ff @(posedge clk_0m002 or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            type_q     <= 3'd0;
            lo_q       <= 8'd0;
            cmd_type_q <= CMD_OFF;
            cmd_data_q <= 16'd0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            lo_q       <= lo_d;
            cmd_type_q <= cmd_type_d;
            cmd_data_q <= cmd_data_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
        end
    end

    assign byte_rdy_o  = rdy_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign cmd_val_o   = (state_q == EMIT);
    assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lights_cmd_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_lights_cmd_deser
// Description : Scoreboard bench for traffic_lights_cmd_deser. A byte-level
//               frame model predicts each command/error and the cycle it
//               must appear in; a monitor pops and compares on every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_lights_cmd_deser;

    localparam int T = 1000;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [7:0]  b_in = 8'd0;
    logic        b_val = 1'b0;
    logic        b_rdy;
    logic [2:0]  cmd_type;
    logic [15:0] cmd_data;
    logic        cmd_val;
    logic        ferr;

    traffic_lights_cmd_deser #(
        .CLK_FREQ_HZ      (2000),
        .FRAME_TIMEOUT_MS (500)
    ) dut (
        .clk_0m002   (clk),
        .arst_i      (arst),
        .byte_i      (b_in),
        .byte_val_i  (b_val),
        .byte_rdy_o  (b_rdy),
        .cmd_type_o  (cmd_type),
        .cmd_data_o  (cmd_data),
        .cmd_val_o   (cmd_val),
        .frame_err_o (ferr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [2:0]  typ;
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t     sb[$];
    bit [7:0] frame[$];
    int       last_acc = 0;
    int       checks = 0;
    int       errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push_err(input int at);
        exp_t e;
        e.is_err = 1'b1; e.typ = 3'd0; e.data = 16'd0; e.at = at;
        sb.push_back(e);
    endfunction

    function automatic void push_cmd(input logic [2:0] t, input logic [15:0] d, input int at);
        exp_t e;
        e.is_err = 1'b0; e.typ = t; e.data = d; e.at = at;
        sb.push_back(e);
    endfunction

    // Frame-level model: a frame is the header plus 0 or 2 payload bytes.
    function automatic void model_byte(input bit [7:0] v, input int at);
        bit       bad;
        bit [2:0] t;
        bit [15:0] d;
        if (frame.size() == 0) begin
            t   = v[2:0];
            bad = (v[7:4] != 4'hA) || v[3];
            `ifdef TL_CMD_RANGE_CHECK_EN
            bad = bad || (t > 3'd5);
            `endif
            if (bad) push_err(at);
            else if (t >= 3'd3 && t <= 3'd5) frame.push_back(v);
            else push_cmd(t, 16'd0, at);
        end else begin
            frame.push_back(v);
            if (frame.size() == 3) begin
                d = {frame[2], frame[1]};
                t = frame[0][2:0];
                `ifdef TL_CMD_RANGE_CHECK_EN
                if (d == 16'd0) push_err(at);
                else push_cmd(t, d, at);
                `else
                push_cmd(t, d, at);
                `endif
                frame.delete();
            end
        end
    endfunction

    // Starts and ends on a falling edge. gap = idle rising edges before the
    // byte is offered.
    task automatic send(input bit [7:0] v, input int gap);
        bit ok;
        if (frame.size() != 0 && gap >= T) begin
            push_err(last_acc + T);
            frame.delete();
        end
        repeat (gap) @(negedge clk);
        b_val = 1'b1;
        b_in  = v;
        ok    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b_rdy) begin
                ok = 1'b1;
                model_byte(v, cyc + 1);
                last_acc = cyc + 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        b_val = 1'b0;
        if (!ok) chk("byte_rdy_wait", 32'd0, 32'd1);
    endtask

    task automatic check_reset_vals();
        chk("rst_rdy", b_rdy, 1'b0);
        chk("rst_cmd_val", cmd_val, 1'b0);
        chk("rst_err", ferr, 1'b0);
        chk("rst_type", cmd_type, 3'd1);
        chk("rst_data", cmd_data, 16'd0);
    endtask

    // Monitor: every strobe/error must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!arst) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                chk("missed_output_at", cyc, sb[0].at);
                void'(sb.pop_front());
            end
            if (cmd_val || ferr) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {cmd_val, ferr}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("is_err", ferr, e.is_err);
                    chk("is_cmd", cmd_val, !e.is_err);
                    chk("out_cycle", cyc, e.at);
                    if (!e.is_err) begin
                        chk("cmd_type", cmd_type, e.typ);
                        chk("cmd_data", cmd_data, e.data);
                        chk("rdy_in_emit", b_rdy, 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] v;
        int       gap;
        repeat (3) @(negedge clk);
        check_reset_vals();
        arst = 1'b0;
        @(negedge clk);
        chk("rdy_after_release", b_rdy, 1'b1);

        // Reset in the middle of a frame drops it.
        send(8'hA4, 0);
        arst = 1'b1;
        frame.delete();
        @(negedge clk);
        check_reset_vals();
        repeat (2) @(negedge clk);
        arst = 1'b0;
        send(8'h30, 0);

        // Data-less commands, back to back.
        send(8'hA0, 0);
        send(8'hA2, 0);
        // Timed command.
        send(8'hA4, 0); send(8'hE8, 0); send(8'h03, 0);
        // Timeout, then a byte landing exactly on the last allowed cycle.
        send(8'hA3, 0); send(8'h10, 0); send(8'hA1, T);
        send(8'hA3, 0); send(8'h10, 0); send(8'h20, T - 1);
        // Bad headers.
        send(8'h55, 0); send(8'hA8, 0);
        // Range-check sensitive frames.
        send(8'hA6, 0);
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);

        // Randomised byte stream.
        for (int n = 0; n < 400; n++) begin
            if (frame.size() == 0) begin
                if ($urandom_range(0, 9) < 8) v = {4'hA, 1'b0, 3'($urandom_range(0, 7))};
                else v = 8'($urandom);
                gap = $urandom_range(0, 2);
            end else begin
                v = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                case ($urandom_range(0, 29))
                    0:       gap = T;
                    1:       gap = T - 1;
                    default: gap = $urandom_range(0, 3);
                endcase
            end
            send(v, gap);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
